// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD requester front end and its engine data path.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        ABORT  = 2'd3
    } state_t;

    localparam int unsigned GCD_WIDTH = 32;

endpackage

// File: rtl/gcd_requester.sv
// Initiator-side front end for the subtract-based GCD engine: request/response handshakes,
// zero-operand short-circuit and a watchdog that aborts and resets a hung engine run.
module gcd_requester
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH          = GCD_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_gcd,
    output logic             rsp_timeout,
    output logic             eng_go,
    output logic [WIDTH-1:0] eng_a,
    output logic [WIDTH-1:0] eng_b,
    input  logic             eng_done,
    input  logic [WIDTH-1:0] eng_result,
    output logic             eng_rst
);

    localparam int unsigned         CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             req_fire;

    assign req_ready = (state == IDLE) && !rsp_valid;
    assign req_fire  = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            rsp_valid   <= 1'b0;
            rsp_gcd     <= '0;
            rsp_timeout <= 1'b0;
            eng_go      <= 1'b0;
            eng_a       <= '0;
            eng_b       <= '0;
            eng_rst     <= 1'b0;
        end else begin
            // Pulses are registered on the entering edge so they coincide with LAUNCH/ABORT.
            eng_go  <= 1'b0;
            eng_rst <= 1'b0;

            if (rsp_valid && rsp_ready)
                rsp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_fire) begin
                        if ((req_a != '0) && (req_b != '0)) begin
                            eng_a  <= req_a;
                            eng_b  <= req_b;
                            eng_go <= 1'b1;
                            state  <= LAUNCH;
                        end else begin
                            rsp_gcd     <= req_a | req_b;
                            rsp_timeout <= 1'b0;
                            rsp_valid   <= 1'b1;
                        end
                    end
                end
                LAUNCH: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (eng_done) begin
                        rsp_gcd     <= eng_result;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= IDLE;
                    end else if (wait_cnt == CNT_LAST) begin
                        eng_rst <= 1'b1;
                        state   <= ABORT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ABORT: begin
                    rsp_gcd     <= '0;
                    rsp_timeout <= 1'b1;
                    rsp_valid   <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
